// File: rtl/amba_read_responder.sv
// APB read completer over a sensor-filled register table; PREADY in access cycle WAIT_STATES+1, held off by sens_lock up to TIMEOUT.
// Optional per-entry parity check is enabled by defining AMBA_READ_PARITY_EN.
module amba_read_responder #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0,
  parameter int          TIMEOUT     = 16,
  localparam int         AW          = $clog2(NUM_REGS)
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [31:0]   PADDR,
  output logic [31:0]   PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  input  logic          sens_we,
  input  logic [AW-1:0] sens_addr,
  input  logic [31:0]   sens_wdata,
  input  logic          sens_lock
`ifdef AMBA_READ_PARITY_EN
  , input  logic        sens_par_inj
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, nxt_idx;
  logic [31:0]    addr_q, addr_cur, off;
  logic [31:0]    mem [NUM_REGS];
  logic [AW-1:0]  idx;
  logic [31:0]    rd_word;
  logic           addr_err, bypass, rd_perr, eval, go;
  logic [31:0]    prdata_nxt;
  logic           pready_nxt, pslverr_nxt;

  // The decision edge for a zero-wait read is the setup edge, so decode the live bus in IDLE.
  always_comb begin
    addr_cur = (state == IDLE) ? PADDR : addr_q;
    off      = addr_cur - BASE_ADDR;
    addr_err = (addr_cur < BASE_ADDR) || (off >= 32'(4 * NUM_REGS)) || (addr_cur[1:0] != 2'b00);
    idx      = off[AW+1:2];
    bypass   = sens_we && (sens_addr == idx);
    rd_word  = bypass ? sens_wdata : mem[idx];
  end

`ifdef AMBA_READ_PARITY_EN
  logic par [NUM_REGS];
  logic rd_par;

  always_comb begin
    rd_par  = bypass ? ((^sens_wdata) ^ sens_par_inj) : par[idx];
    rd_perr = (^rd_word) != rd_par;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) par[i] <= 1'b0;
    end else if (sens_we) begin
      par[sens_addr] <= (^sens_wdata) ^ sens_par_inj;
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= 32'h0;
    end else if (sens_we) begin
      mem[sens_addr] <= sens_wdata;
    end
  end

  // nxt_idx is the access-cycle number (1-based) the next cycle would be.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = 32'h0;
    eval        = 1'b0;
    go          = 1'b0;
    nxt_idx     = (state == IDLE) ? CW'(1) : cnt + CW'(2);
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE && !PWRITE) begin
          go        = 1'b1;
          eval      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (PSEL && PENABLE) begin
          eval    = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (eval) begin
      if ((nxt_idx >= CW'(WAIT_STATES + 1)) && (addr_err || !sens_lock)) begin
        state_nxt  = RESP;
        pready_nxt = 1'b1;
        if (addr_err || rd_perr) pslverr_nxt = 1'b1;
        else                     prdata_nxt  = rd_word;
      end else if (nxt_idx >= CW'(TIMEOUT)) begin
        state_nxt   = RESP;
        pready_nxt  = 1'b1;
        pslverr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= 32'h0;
      PRDATA  <= 32'h0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (go) addr_q <= PADDR;
      PRDATA  <= prdata_nxt;
      PREADY  <= pready_nxt;
      PSLVERR <= pslverr_nxt;
    end
  end

endmodule

// File: tb/tb_amba_read_responder.sv
// Directed bench for amba_read_responder: BASE_ADDR=0x100, 16 regs, 2 wait states, timeout 16.
module tb_amba_read_responder;
  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h100;

  logic          PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0]   PADDR, PRDATA;
  logic          PREADY, PSLVERR;
  logic          sens_we, sens_lock, sens_par_inj;
  logic [AW-1:0] sens_addr;
  logic [31:0]   sens_wdata;

  int total = 0;
  int bad   = 0;

  amba_read_responder #(
    .NUM_REGS(16), .BASE_ADDR(BASE), .WAIT_STATES(2), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sens_we(sens_we), .sens_addr(sens_addr), .sens_wdata(sens_wdata), .sens_lock(sens_lock)
`ifdef AMBA_READ_PARITY_EN
    , .sens_par_inj(sens_par_inj)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic sens_write(input logic [AW-1:0] i, input logic [31:0] d, input logic inj);
    sens_we = 1'b1; sens_addr = i; sens_wdata = d; sens_par_inj = inj;
    tick();
    sens_we = 1'b0; sens_par_inj = 1'b0;
  endtask

  // Full read transfer; optionally fires a sensor write during access cycle we_at.
  task automatic apb_read(input logic [31:0] a, input int we_at, input logic [AW-1:0] we_i,
                          input logic [31:0] we_d, output logic [31:0] d, output logic e,
                          output int cyc, output logic after_rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick();
    PENABLE = 1'b1;
    cyc = -1; d = 32'hx; e = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (PREADY) begin
        cyc = k; d = PRDATA; e = PSLVERR;
        break;
      end
      if (k == we_at) begin
        sens_we = 1'b1; sens_addr = we_i; sens_wdata = we_d;
      end
      tick();
      sens_we = 1'b0;
    end
    tick();
    after_rdy = PREADY;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] d;
  logic        e, after_rdy, seen;
  int          cyc;

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
    sens_we = 1'b0; sens_lock = 1'b0; sens_par_inj = 1'b0; sens_addr = '0; sens_wdata = 32'h0;
    tick(); tick();
    check("rst_pready", {31'b0, PREADY}, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    PRESET = 1'b0;
    tick();

    // Basic read with two wait states
    sens_write(4'd5, 32'hFFFF0000, 1'b0);
    apb_read(BASE + 32'h14, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t1_cycle", 32'(cyc), 32'd3);
    check("t1_data", d, 32'hFFFF0000);
    check("t1_err", {31'b0, e}, 32'h0);
    check("t1_pulse", {31'b0, after_rdy}, 32'h0);

    // Decode errors and the last valid entry
    apb_read(BASE + 32'h13, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t2_unal_cycle", 32'(cyc), 32'd3);
    check("t2_unal_err", {31'b0, e}, 32'h1);
    check("t2_unal_data", d, 32'h0);
    apb_read(BASE + 32'h40, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t2_over_err", {31'b0, e}, 32'h1);
    check("t2_over_data", d, 32'h0);
    apb_read(BASE - 32'h4, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t2_under_err", {31'b0, e}, 32'h1);
    apb_read(BASE + 32'h3C, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t2_last_err", {31'b0, e}, 32'h0);

    // Lock stall to timeout; decode error is not stalled by the lock
    sens_lock = 1'b1;
    apb_read(BASE + 32'h14, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t3_tmo_cycle", 32'(cyc), 32'd16);
    check("t3_tmo_err", {31'b0, e}, 32'h1);
    check("t3_tmo_data", d, 32'h0);
    apb_read(BASE + 32'h40, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t3_lock_decode_cycle", 32'(cyc), 32'd3);
    sens_lock = 1'b0;
    apb_read(BASE + 32'h14, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t3_unlock_data", d, 32'hFFFF0000);
    check("t3_unlock_err", {31'b0, e}, 32'h0);

    // Write-first bypass on the capture edge
    apb_read(BASE + 32'h14, 2, 4'd5, 32'hA5A5A5A5, d, e, cyc, after_rdy);
    check("t4_bypass_data", d, 32'hA5A5A5A5);
    check("t4_bypass_cycle", 32'(cyc), 32'd3);
    apb_read(BASE + 32'h14, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t4_stored", d, 32'hA5A5A5A5);

    // Reset mid-access aborts the transfer and clears the table
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = BASE + 32'h14;
    tick();
    PENABLE = 1'b1;
    tick();
    #1 PRESET = 1'b1;
    #1;
    check("t5_rst_pready", {31'b0, PREADY}, 32'h0);
    check("t5_rst_prdata", PRDATA, 32'h0);
    #1 PRESET = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | PREADY;
    end
    check("t5_no_pready", {31'b0, seen}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    apb_read(BASE + 32'h14, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t5_post_data", d, 32'h0);
    check("t5_post_err", {31'b0, e}, 32'h0);

    // Write-direction setup is ignored
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE;
    tick();
    PENABLE = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | PREADY;
    end
    check("pwrite_ignored", {31'b0, seen}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick();

`ifdef AMBA_READ_PARITY_EN
    sens_write(4'd3, 32'h1, 1'b1);
    apb_read(BASE + 32'hC, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t6_inj_err", {31'b0, e}, 32'h1);
    check("t6_inj_data", d, 32'h0);
    sens_write(4'd3, 32'h1, 1'b0);
    apb_read(BASE + 32'hC, 0, '0, 32'h0, d, e, cyc, after_rdy);
    check("t6_ok_err", {31'b0, e}, 32'h0);
    check("t6_ok_data", d, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
